// File: rtl/mem_bus_pkg.sv
// Shared bus widths, default line geometry and the master FSM state type
// for the 6-bit-address / 32-bit-data memory bus.
package mem_bus_pkg;

    localparam int MEM_AW             = 6;
    localparam int MEM_DW             = 32;
    localparam int DEF_LINE_WORDS     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

endpackage

// File: rtl/mem_bus_timeout.sv
// Cycle counter with clear/enable that flags when CYCLES enabled cycles
// have elapsed since the last clear; it holds at the limit until cleared.
module mem_bus_timeout #(
    parameter int CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(CYCLES - 1));

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator: splits one line fill or writeback into LINE_WORDS single-word
// transactions, waiting out the responder's stale ready between words.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int LINE_WORDS     = DEF_LINE_WORDS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [MEM_AW-1:0]            req_addr,
    input  logic [MEM_DW*LINE_WORDS-1:0] req_wline,
    output logic                         rsp_valid,
    output logic [3:0]                   rsp_idx,
    output logic [MEM_DW-1:0]            rsp_rdata,
    output logic                         done,
    output logic                         err,
    output logic [MEM_AW-1:0]            mem_addr,
    inout  wire  [MEM_DW-1:0]            mem_data,
    output logic                         mem_cs,
    output logic                         mem_rd,
    output logic                         mem_wr,
    input  logic                         mem_ready
);

    localparam logic [MEM_AW-1:0] OFF_MASK = MEM_AW'(LINE_WORDS - 1);
    localparam logic [3:0]        LAST_IDX = 4'(LINE_WORDS - 1);

    state_t                      state;
    state_t                      state_next;
    logic                        we_q;
    logic                        abort_q;
    logic [MEM_AW-1:0]           base_q;
    logic [3:0]                  k;
    logic [MEM_DW*LINE_WORDS-1:0] line_q;
    logic [MEM_DW-1:0]           wdata;

    logic                        accept;
    logic                        last;
    logic                        word_done;
    logic                        timeout_hit;
    logic                        gap_exit;
    logic                        issue_next;
    logic                        we_next;
    logic [MEM_AW-1:0]           addr_next;
    logic                        expired;

    mem_bus_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != ISSUE),
        .enable  (state == ISSUE),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A real ready always wins over the timeout, even on the last allowed cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   if (mem_ready || expired) state_next = GAP;
            GAP:     if (!mem_ready) state_next = (abort_q || last) ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        accept      = req_valid && req_ready;
        last        = (k == LAST_IDX);
        word_done   = (state == ISSUE) && mem_ready;
        timeout_hit = (state == ISSUE) && !mem_ready && expired;
        gap_exit    = (state == GAP) && !mem_ready;
        issue_next  = (state_next == ISSUE);
        we_next     = accept ? req_we : we_q;
        addr_next   = mem_addr;
        if (accept) begin
            addr_next = req_addr & ~OFF_MASK;
        end else if (gap_exit && issue_next) begin
            addr_next = base_q | MEM_AW'(k + 4'd1);
        end
    end

    // Strobes are registered copies of "next state is ISSUE", so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cs    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
            rsp_rdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            base_q    <= '0;
            k         <= '0;
            line_q    <= '0;
        end else begin
            mem_cs    <= issue_next;
            mem_rd    <= issue_next && !we_next;
            mem_wr    <= issue_next && we_next;
            mem_addr  <= addr_next;
            rsp_valid <= word_done && !we_q;
            done      <= gap_exit && last && !abort_q;
            err       <= timeout_hit;
            if (word_done && !we_q) begin
                rsp_idx   <= k;
                rsp_rdata <= mem_data;
            end
            if (accept) begin
                we_q    <= req_we;
                base_q  <= req_addr & ~OFF_MASK;
                line_q  <= req_wline;
                k       <= '0;
                abort_q <= 1'b0;
            end else begin
                if (timeout_hit) begin
                    abort_q <= 1'b1;
                end
                if (gap_exit && issue_next) begin
                    k <= k + 4'd1;
                end
            end
        end
    end

    assign wdata    = line_q[MEM_DW*k +: MEM_DW];
    assign mem_data = (mem_cs && mem_wr) ? wdata : {MEM_DW{1'bz}};

endmodule
